// File: rtl/state_rmw.sv
// state_rmw
// ---------
// Initiator-side read-modify-write client for a single-register state holder.
// Each command is handled one at a time: an add command reads the holder,
// adds its delta (wrapping or saturating), and writes the sum back. A set
// command writes its data straight through without reading. After the write
// the new value is reported on dout. The command is acknowledged only when
// dout transfers, so a reset mid-operation makes upstream re-present it.
//
// Ports (every channel uses valid/ready; a transfer is valid && ready):
//   clk, rst        clock, synchronous active-high reset
//   cmd_*           command in; cmd_data[W] = set flag, cmd_data[W-1:0] = value
//   rd_req_*        read request to the state holder (payload tied to 0)
//   rd_data_*       value returned by the state holder
//   wr_*            new value written to the state holder
//   dout_*          updated value reported downstream
module state_rmw #(
    parameter int           W    = 16,
    parameter bit           SAT  = 1'b0,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W:0]   cmd_data,

    output logic         rd_req_valid,
    input  logic         rd_req_ready,
    output logic         rd_req_data,

    input  logic         rd_data_valid,
    output logic         rd_data_ready,
    input  logic [W-1:0] rd_data_data,

    output logic         wr_valid,
    input  logic         wr_ready,
    output logic [W-1:0] wr_data,

    output logic         dout_valid,
    input  logic         dout_ready,
    output logic [W-1:0] dout_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] result_q, result_d;
    logic         req_done_q, req_done_d;

    logic [W:0]   sum;
    logic [W-1:0] sum_fit;

    // One extra bit of headroom so the carry tells us whether the add overflowed.
    assign sum = {1'b0, rd_data_data} + {1'b0, cmd_data[W-1:0]};

    always_comb begin
        sum_fit = sum[W-1:0];
        if (SAT && sum[W]) begin
            sum_fit = '1;
        end
    end

    // Next-state logic. The command is never captured: cmd_data is held stable
    // by the producer until it is acknowledged, so it is read directly in IDLE
    // and RD. req_done remembers that the read request already transferred
    // while we still wait for the data, so the request is not issued twice.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        req_done_d = req_done_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_data[W]) begin
                        result_d = cmd_data[W-1:0];
                        state_d  = WR;
                    end else begin
                        state_d  = RD;
                    end
                end
            end
            RD: begin
                if (rd_req_valid && rd_req_ready) begin
                    req_done_d = 1'b1;
                end
                // rd_data_ready is always high in RD, so valid alone is a transfer.
                if (rd_data_valid) begin
                    result_d   = sum_fit;
                    req_done_d = 1'b0;
                    state_d    = WR;
                end
            end
            WR: begin
                if (wr_ready) begin
                    state_d = OUT;
                end
            end
            OUT: begin
                if (dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            result_q   <= INIT;
            req_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            req_done_q <= req_done_d;
        end
    end

    // Outputs decode registered state only, except cmd_ready which retires the
    // command in the very cycle dout transfers.
    assign rd_req_valid  = (state_q == RD) && !req_done_q;
    assign rd_req_data   = 1'b0;
    assign rd_data_ready = (state_q == RD);
    assign wr_valid      = (state_q == WR);
    assign wr_data       = result_q;
    assign dout_valid    = (state_q == OUT);
    assign dout_data     = result_q;
    assign cmd_ready     = (state_q == OUT) && dout_ready;

endmodule

// File: tb/tb_state_rmw.sv
// tb_state_rmw
// ------------
// Drives state_rmw (wrapping instance) through directed and randomized
// read-modify-write traffic against a behavioural state-holder model, and a
// second saturating instance through a few directed boundary additions.
// Outputs are sampled on the falling edge; inputs change just after the
// rising edge.
module tb_state_rmw;

    localparam int W = 16;

    logic         clk;
    logic         rst;

    logic         cmd_valid, cmd_ready;
    logic [W:0]   cmd_data;
    logic         rd_req_valid, rd_req_ready, rd_req_data;
    logic         rd_data_valid, rd_data_ready;
    logic [W-1:0] rd_data_data;
    logic         wr_valid, wr_ready;
    logic [W-1:0] wr_data;
    logic         dout_valid, dout_ready;
    logic [W-1:0] dout_data;

    // State holder model: register, preload port, and delayed read response.
    logic [W-1:0] holder;
    logic         preload_en;
    logic [W-1:0] preload_val;
    logic         hold_pend;
    logic [1:0]   hold_cnt;
    logic [1:0]   delay_sel;

    // Saturating instance with an always-ready, zero-latency holder.
    logic         s_cmd_valid, s_cmd_ready;
    logic [W:0]   s_cmd_data;
    logic         s_rd_req_valid, s_rd_req_data, s_rd_data_ready;
    logic [W-1:0] s_hold;
    logic         s_wr_valid, s_dout_valid;
    logic [W-1:0] s_wr_data, s_dout_data;
    logic         s_one;

    int checks;
    int errors;

    // Model bookkeeping for the command currently in flight.
    int           rdreq_cnt;
    int           rddata_cnt;
    bit           wr_done;
    logic [W-1:0] wr_val;
    bit           retired;
    logic [W-1:0] dout_q[$];

    bit           prev_rst;
    logic         prev_rqv, prev_rqr, prev_rq_f, prev_rd_f;
    logic         prev_wrv, prev_wrr, prev_dov, prev_dor;
    logic [W-1:0] prev_wrd, prev_dod;

    // Falling-edge snapshots for directed checks.
    logic         o_rdreq, o_rdr, o_wrv, o_doutv, o_cmdr;
    logic [W-1:0] o_wrd, o_doutd;
    logic         s_o_rdreq, s_o_rdr, s_o_rqd, s_o_wrv, s_o_doutv, s_o_cmdr;
    logic [W-1:0] s_o_wrd, s_o_doutd;

    state_rmw #(.W(W), .SAT(1'b0), .INIT('0)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_data  (rd_req_data),
        .rd_data_valid(rd_data_valid),
        .rd_data_ready(rd_data_ready),
        .rd_data_data (rd_data_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .dout_data    (dout_data)
    );

    assign s_one = 1'b1;

    state_rmw #(.W(W), .SAT(1'b1), .INIT('0)) dut_sat (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (s_cmd_valid),
        .cmd_ready    (s_cmd_ready),
        .cmd_data     (s_cmd_data),
        .rd_req_valid (s_rd_req_valid),
        .rd_req_ready (s_one),
        .rd_req_data  (s_rd_req_data),
        .rd_data_valid(s_rd_req_valid),
        .rd_data_ready(s_rd_data_ready),
        .rd_data_data (s_hold),
        .wr_valid     (s_wr_valid),
        .wr_ready     (s_one),
        .wr_data      (s_wr_data),
        .dout_valid   (s_dout_valid),
        .dout_ready   (s_one),
        .dout_data    (s_dout_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Holder answers in the request cycle when delay_sel is 0, otherwise
    // delay_sel cycles after the request transfers.
    assign rd_data_valid = hold_pend ? (hold_cnt == 2'd0)
                                     : (rd_req_valid && rd_req_ready && delay_sel == 2'd0);
    assign rd_data_data  = holder;

    always @(posedge clk) begin
        if (preload_en) begin
            holder <= preload_val;
        end else if (wr_valid && wr_ready) begin
            holder <= wr_data;
        end
        if (rst) begin
            hold_pend <= 1'b0;
        end else if (hold_pend) begin
            if (hold_cnt == 2'd0) begin
                if (rd_data_ready) begin
                    hold_pend <= 1'b0;
                end
            end else begin
                hold_cnt <= hold_cnt - 2'd1;
            end
        end else if (rd_req_valid && rd_req_ready && delay_sel != 2'd0) begin
            hold_pend <= 1'b1;
            hold_cnt  <= delay_sel - 2'd1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the transaction-level model: every write
    // must carry set-data or holder+delta mod 2^W, be preceded by exactly one
    // read for adds and none for sets, and every dout must repeat the value
    // written and coincide with exactly one command acknowledge.
    task automatic checkCycle();
        logic rq_f, rd_f, wr_f, do_f;
        int   exp_wr;
        rq_f = rd_req_valid && rd_req_ready;
        rd_f = rd_data_valid && rd_data_ready;
        wr_f = wr_valid && wr_ready;
        do_f = dout_valid && dout_ready;
        if (prev_rst) begin
            checkOutput("reset_outputs",
                32'({rd_req_valid, rd_data_ready, wr_valid, dout_valid, cmd_ready}), 32'(0));
        end
        if (rst) begin
            rdreq_cnt  = 0;
            rddata_cnt = 0;
            wr_done    = 1'b0;
        end else begin
            checkOutput("cmd_ack", 32'(cmd_ready), 32'(do_f));
            if (!cmd_valid) begin
                checkOutput("idle_outputs",
                    32'({rd_req_valid, rd_data_ready, wr_valid, dout_valid}), 32'(0));
            end
            if (rd_req_valid) begin
                checkOutput("rd_req_data", 32'(rd_req_data), 32'(0));
            end
            if (!prev_rst) begin
                if (prev_wrv && !prev_wrr) begin
                    checkOutput("wr_hold", 32'({wr_valid, wr_data}), 32'({1'b1, prev_wrd}));
                end
                if (prev_dov && !prev_dor) begin
                    checkOutput("dout_hold", 32'({dout_valid, dout_data}), 32'({1'b1, prev_dod}));
                end
                if (prev_rqv && !prev_rqr) begin
                    checkOutput("rd_req_hold", 32'(rd_req_valid), 32'(1));
                end
                if (prev_rq_f) begin
                    checkOutput("rd_req_drop", 32'(rd_req_valid), 32'(0));
                end
                if (prev_rq_f && !prev_rd_f) begin
                    checkOutput("rd_wait_ready", 32'(rd_data_ready), 32'(1));
                end
            end
            if (rd_f) begin
                checkOutput("rd_after_req", rdreq_cnt + int'(rq_f), 1);
            end
            if (wr_f) begin
                if (cmd_data[W]) begin
                    exp_wr = int'(cmd_data[W-1:0]);
                end else begin
                    exp_wr = (int'(holder) + int'(cmd_data[W-1:0])) % (1 << W);
                end
                checkOutput("wr_data", 32'(wr_data), exp_wr);
                checkOutput("wr_read_count", rddata_cnt, cmd_data[W] ? 0 : 1);
                checkOutput("wr_req_count", rdreq_cnt, cmd_data[W] ? 0 : 1);
                checkOutput("wr_once", 32'(wr_done), 32'(0));
                wr_done = 1'b1;
                wr_val  = exp_wr[W-1:0];
            end
            if (do_f) begin
                checkOutput("dout_after_wr", 32'(wr_done), 32'(1));
                checkOutput("dout_data", 32'(dout_data), 32'(wr_val));
                dout_q.push_back(dout_data);
                retired    = cmd_valid;
                rdreq_cnt  = 0;
                rddata_cnt = 0;
                wr_done    = 1'b0;
            end
            rdreq_cnt  += int'(rq_f);
            rddata_cnt += int'(rd_f);
        end
        prev_rqv  = rd_req_valid;
        prev_rqr  = rd_req_ready;
        prev_rq_f = rq_f;
        prev_rd_f = rd_f;
        prev_wrv  = wr_valid;
        prev_wrr  = wr_ready;
        prev_wrd  = wr_data;
        prev_dov  = dout_valid;
        prev_dor  = dout_ready;
        prev_dod  = dout_data;
        prev_rst  = rst;
    endtask

    task automatic stepCycle();
        @(negedge clk);
        o_rdreq   = rd_req_valid;
        o_rdr     = rd_data_ready;
        o_wrv     = wr_valid;
        o_wrd     = wr_data;
        o_doutv   = dout_valid;
        o_doutd   = dout_data;
        o_cmdr    = cmd_ready;
        s_o_rdreq = s_rd_req_valid;
        s_o_rdr   = s_rd_data_ready;
        s_o_rqd   = s_rd_req_data;
        s_o_wrv   = s_wr_valid;
        s_o_wrd   = s_wr_data;
        s_o_doutv = s_dout_valid;
        s_o_doutd = s_dout_data;
        s_o_cmdr  = s_cmd_ready;
        checkCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic allReady();
        rd_req_ready = 1'b1;
        wr_ready     = 1'b1;
        dout_ready   = 1'b1;
        delay_sel    = 2'd0;
    endtask

    task automatic applyStimulus();
        rd_req_ready = ($urandom_range(0, 3) != 0);
        wr_ready     = ($urandom_range(0, 2) != 0);
        dout_ready   = ($urandom_range(0, 2) != 0);
        delay_sel    = 2'($urandom_range(0, 3));
    endtask

    task automatic preloadHolder(input logic [W-1:0] h);
        preload_en  = 1'b1;
        preload_val = h;
        stepCycle();
        preload_en  = 1'b0;
    endtask

    // Presents one command and runs until it is acknowledged. cmd_valid is left
    // high so the caller can chain commands back to back.
    task automatic runCmd(input logic is_set, input logic [W-1:0] d, input bit rnd);
        cmd_valid = 1'b1;
        cmd_data  = {is_set, d};
        retired   = 1'b0;
        for (int n = 0; n < 200 && !retired; n++) begin
            if (rnd) begin
                applyStimulus();
            end
            stepCycle();
        end
        checkOutput("cmd_retired", 32'(retired), 32'(1));
    endtask

    task automatic directedAdd(input logic [W-1:0] h, input logic [W-1:0] d, input logic [W-1:0] expw);
        preloadHolder(h);
        allReady();
        cmd_valid = 1'b1;
        cmd_data  = {1'b0, d};
        stepCycle();
        checkOutput("add_c0_idle", 32'({o_rdreq, o_wrv, o_doutv}), 32'(0));
        stepCycle();
        checkOutput("add_c1_rdreq", 32'({o_rdreq, o_wrv}), 32'(2'b10));
        stepCycle();
        checkOutput("add_c2_wr", 32'({o_wrv, o_wrd}), 32'({1'b1, expw}));
        stepCycle();
        checkOutput("add_c3_dout", 32'({o_doutv, o_cmdr, o_doutd}), 32'({2'b11, expw}));
        cmd_valid = 1'b0;
        stepCycle();
    endtask

    task automatic directedSet(input logic [W-1:0] d);
        allReady();
        cmd_valid = 1'b1;
        cmd_data  = {1'b1, d};
        stepCycle();
        checkOutput("set_c0_idle", 32'({o_rdreq, o_wrv, o_doutv}), 32'(0));
        stepCycle();
        checkOutput("set_c1_wr", 32'({o_rdreq, o_wrv, o_wrd}), 32'({2'b01, d}));
        stepCycle();
        checkOutput("set_c2_dout", 32'({o_doutv, o_cmdr, o_doutd}), 32'({2'b11, d}));
        cmd_valid = 1'b0;
        stepCycle();
        checkOutput("set_holder", 32'(holder), 32'(d));
    endtask

    task automatic runSat(input logic [W-1:0] h, input logic [W-1:0] d, input logic [W-1:0] expw);
        s_hold      = h;
        s_cmd_valid = 1'b1;
        s_cmd_data  = {1'b0, d};
        stepCycle();
        checkOutput("sat_c0_idle", 32'({s_o_rdreq, s_o_wrv, s_o_doutv}), 32'(0));
        stepCycle();
        checkOutput("sat_c1_rd", 32'({s_o_rdreq, s_o_rdr, s_o_rqd}), 32'(3'b110));
        stepCycle();
        checkOutput("sat_c2_wr", 32'({s_o_wrv, s_o_wrd}), 32'({1'b1, expw}));
        stepCycle();
        checkOutput("sat_c3_dout", 32'({s_o_doutv, s_o_cmdr, s_o_doutd}), 32'({2'b11, expw}));
        s_cmd_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rdreq_cnt   = 0;
        rddata_cnt  = 0;
        wr_done     = 1'b0;
        wr_val      = '0;
        retired     = 1'b0;
        prev_rst    = 1'b0;
        prev_rqv    = 1'b0;
        prev_rqr    = 1'b0;
        prev_rq_f   = 1'b0;
        prev_rd_f   = 1'b0;
        prev_wrv    = 1'b0;
        prev_wrr    = 1'b0;
        prev_wrd    = '0;
        prev_dov    = 1'b0;
        prev_dor    = 1'b0;
        prev_dod    = '0;
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_data    = '0;
        preload_en  = 1'b1;
        preload_val = '0;
        s_cmd_valid = 1'b0;
        s_cmd_data  = '0;
        s_hold      = '0;
        allReady();

        @(posedge clk);
        #1;
        stepCycle();
        stepCycle();
        rst        = 1'b0;
        preload_en = 1'b0;
        stepCycle();
        checkOutput("reset_state",
            32'({o_rdreq, o_rdr, o_wrv, o_doutv, o_cmdr, s_o_rdreq, s_o_wrv, s_o_doutv, s_o_cmdr}), 32'(0));

        $display("[TB] directed latency and arithmetic");
        directedAdd(16'h0005, 16'h0003, 16'h0008);
        directedAdd(16'hFFFE, 16'h0005, 16'h0003);
        directedAdd(16'hFFFF, 16'h0001, 16'h0000);
        directedSet(16'h1234);

        $display("[TB] saturating instance");
        runSat(16'hFFFE, 16'h0005, 16'hFFFF);
        runSat(16'hFFFE, 16'h0001, 16'hFFFF);
        runSat(16'h8000, 16'h8000, 16'hFFFF);
        runSat(16'h0005, 16'h0003, 16'h0008);

        $display("[TB] backpressure sweep");
        preloadHolder(16'h0000);
        dout_q.delete();
        runCmd(1'b0, 16'd1, 1'b1);
        runCmd(1'b0, 16'd2, 1'b1);
        runCmd(1'b0, 16'd3, 1'b1);
        cmd_valid = 1'b0;
        allReady();
        stepCycle();
        checkOutput("sweep_count", dout_q.size(), 3);
        if (dout_q.size() == 3) begin
            checkOutput("sweep_dout0", 32'(dout_q[0]), 32'(1));
            checkOutput("sweep_dout1", 32'(dout_q[1]), 32'(3));
            checkOutput("sweep_dout2", 32'(dout_q[2]), 32'(6));
        end
        checkOutput("sweep_final_state", 32'(holder), 32'(6));

        $display("[TB] reset while reading");
        preloadHolder(16'h0010);
        allReady();
        delay_sel = 2'd3;
        cmd_valid = 1'b1;
        cmd_data  = {1'b0, 16'h0002};
        stepCycle();
        stepCycle();
        checkOutput("r1_rdreq", 32'(o_rdreq), 32'(1));
        stepCycle();
        checkOutput("r1_waiting", 32'({o_rdreq, o_rdr}), 32'(2'b01));
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("r1_after_reset", 32'({o_rdreq, o_rdr, o_wrv, o_doutv}), 32'(0));
        checkOutput("r1_holder", 32'(holder), 32'(16'h0010));
        delay_sel = 2'd0;
        dout_q.delete();
        runCmd(1'b0, 16'h0002, 1'b0);
        cmd_valid = 1'b0;
        stepCycle();
        checkOutput("r1_replay_count", dout_q.size(), 1);
        if (dout_q.size() == 1) begin
            checkOutput("r1_replay_dout", 32'(dout_q[0]), 32'(16'h0012));
        end
        checkOutput("r1_replay_holder", 32'(holder), 32'(16'h0012));

        $display("[TB] reset while write stalled");
        preloadHolder(16'h0020);
        allReady();
        wr_ready  = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = {1'b0, 16'h0001};
        stepCycle();
        stepCycle();
        stepCycle();
        checkOutput("r2_wr_stalled", 32'({o_wrv, o_wrd}), 32'({1'b1, 16'h0021}));
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("r2_after_reset", 32'(o_wrv), 32'(0));
        checkOutput("r2_holder", 32'(holder), 32'(16'h0020));
        wr_ready = 1'b1;
        dout_q.delete();
        runCmd(1'b0, 16'h0001, 1'b0);
        cmd_valid = 1'b0;
        stepCycle();
        checkOutput("r2_replay_holder", 32'(holder), 32'(16'h0021));

        $display("[TB] randomized commands");
        preloadHolder(16'($urandom));
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] d;
            case ($urandom_range(0, 3))
                0:       d = 16'h0000;
                1:       d = 16'hFFFF;
                default: d = 16'($urandom);
            endcase
            runCmd(($urandom_range(0, 3) == 0), d, 1'b1);
        end
        cmd_valid = 1'b0;
        allReady();
        stepCycle();
        stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
